// File: rtl/uart_rx_8n1_pkg.sv
// Shared definitions for the 8N1 UART blocks: frame geometry, default bit
// timing and the receiver state encoding.
package uart_rx_8n1_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Receive-side result bundle: the receiver drives it (master), user logic
// consumes it (slave).
interface uart_rx_8n1_if;
    import uart_rx_8n1_pkg::*;

    logic [UART_DATA_BITS-1:0] rxbyte;
    logic                      rxdone;
    logic                      rxerr;
    logic                      busy;

    modport master (output rxbyte, rxdone, rxerr, busy);
    modport slave  (input  rxbyte, rxdone, rxerr, busy);

endinterface

// File: rtl/uart_rx_8n1_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input line.
module uart_rx_8n1_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: both flops reset to the idle level (1) so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling at CLKS_PER_BIT clocks per bit,
// one-cycle rxdone / rxerr strobes, break hold-off after a framing error.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_rx_8n1_if.master bus
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    uart_state_e               state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bitidx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      rx_s;

    uart_rx_8n1_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitidx     <= '0;
            shift      <= '0;
            bus.rxbyte <= '0;
            bus.rxdone <= 1'b0;
            bus.rxerr  <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            // NOTE: strobes default low here and are raised only by the branch that completes a frame.
            bus.rxdone <= 1'b0;
            bus.rxerr  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state  <= ST_DATA;
                            bitidx <= '0;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        shift  <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        bitidx <= bitidx + 3'd1;
                        if (bitidx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            bus.rxbyte <= shift;
                            bus.rxdone <= 1'b1;
                            state      <= ST_IDLE;
                            bus.busy   <= 1'b0;
                        end else begin
                            bus.rxerr <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    // A line held low must return high before a new frame can start.
                    if (rx_s) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: three instances (16, 4 and 10 clocks
// per bit) driven with directed and random frames against a timing/byte model.
module tb_uart_rx_8n1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        done;
        logic        err;
        logic [7:0]  data;
        logic        busy;
    } ev_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_v [3];
    logic [31:0] cyc   = '0;

    int n_vec  = 0;
    int n_fail = 0;

    ev_t        ev_q  [3][$];
    ev_t        exp_q [3][$];
    logic [7:0] last_byte [3];

    uart_rx_8n1_if u_if16 ();
    uart_rx_8n1_if u_if4  ();
    uart_rx_8n1_if u_if10 ();

    uart_rx_8n1 #(.CLKS_PER_BIT(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .bus(u_if16));
    uart_rx_8n1 #(.CLKS_PER_BIT(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .bus(u_if4));
    uart_rx_8n1 #(.CLKS_PER_BIT(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .bus(u_if10));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic ev_t mk_ev(input logic [31:0] c, input logic d, input logic e,
                                  input logic [7:0] b, input logic bz);
        ev_t r;
        r.cyc  = c;
        r.done = d;
        r.err  = e;
        r.data = b;
        r.busy = bz;
        return r;
    endfunction

    function automatic int cpb_of(input int sel);
        case (sel)
            0:       return 16;
            1:       return 4;
            default: return 10;
        endcase
    endfunction

    // Outputs are logged half a cycle after each active edge.
    always @(negedge clk) begin
        if (u_if16.rxdone || u_if16.rxerr)
            ev_q[0].push_back(mk_ev(cyc, u_if16.rxdone, u_if16.rxerr, u_if16.rxbyte, u_if16.busy));
        if (u_if4.rxdone || u_if4.rxerr)
            ev_q[1].push_back(mk_ev(cyc, u_if4.rxdone, u_if4.rxerr, u_if4.rxbyte, u_if4.busy));
        if (u_if10.rxdone || u_if10.rxerr)
            ev_q[2].push_back(mk_ev(cyc, u_if10.rxdone, u_if10.rxerr, u_if10.rxbyte, u_if10.busy));
    end

    // Drives one whole frame starting at the current negedge and records the
    // strobe the model expects: the fall is seen at E1, sampled at E3, and the
    // stop bit is judged HALF + 9 bit times later.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic stop_bit);
        int          c;
        logic [31:0] fall;
        c    = cpb_of(sel);
        fall = cyc;
        rx_v[sel] = 1'b0;
        repeat (c) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_v[sel] = data[i];
            repeat (c) @(negedge clk);
        end
        rx_v[sel] = stop_bit;
        repeat (c) @(negedge clk);
        if (stop_bit) begin
            last_byte[sel] = data;
            exp_q[sel].push_back(mk_ev(fall + 32'(3 + c / 2 + 9 * c), 1'b1, 1'b0, data, 1'b0));
        end else begin
            exp_q[sel].push_back(mk_ev(fall + 32'(3 + c / 2 + 9 * c), 1'b0, 1'b1, last_byte[sel], 1'b1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({u_if16.rxbyte, u_if16.rxdone, u_if16.rxerr, u_if16.busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset16 got %h/%b/%b/%b want 00/0/0/0", u_if16.rxbyte, u_if16.rxdone, u_if16.rxerr, u_if16.busy);
        end
        n_vec++;
        if ({u_if4.rxbyte, u_if4.rxdone, u_if4.rxerr, u_if4.busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset4 got %h/%b/%b/%b want 00/0/0/0", u_if4.rxbyte, u_if4.rxdone, u_if4.rxerr, u_if4.busy);
        end
        n_vec++;
        if ({u_if10.rxbyte, u_if10.rxdone, u_if10.rxerr, u_if10.busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset10 got %h/%b/%b/%b want 00/0/0/0", u_if10.rxbyte, u_if10.rxdone, u_if10.rxerr, u_if10.busy);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_vec++;
        if ({u_if16.busy, u_if4.busy, u_if10.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset busy got %b%b%b want 000", u_if16.busy, u_if4.busy, u_if10.busy);
        end
    endtask

    task automatic test_single_and_random();
        int gap;
        @(negedge clk);
        send_frame(0, 8'h25, 1'b1);
        for (int n = 0; n < 4; n++) begin
            gap = int'($urandom_range(0, 30));
            repeat (gap) @(negedge clk);
            send_frame(0, 8'($urandom), 1'b1);
        end
        repeat (24) @(negedge clk);
        n_vec++;
        if (ev_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL single_count got %0d strobes want %0d", ev_q[0].size(), exp_q[0].size());
        end
        for (int k = 0; k < exp_q[0].size() && k < ev_q[0].size(); k++) begin
            n_vec++;
            if (ev_q[0][k] !== exp_q[0][k]) begin
                n_fail++;
                $display("FAIL single_ev%0d got cyc=%0d done=%b err=%b byte=%h busy=%b want cyc=%0d done=%b err=%b byte=%h busy=%b",
                         k, ev_q[0][k].cyc, ev_q[0][k].done, ev_q[0][k].err, ev_q[0][k].data, ev_q[0][k].busy,
                         exp_q[0][k].cyc, exp_q[0][k].done, exp_q[0][k].err, exp_q[0][k].data, exp_q[0][k].busy);
            end
        end
        ev_q[0].delete();
        exp_q[0].delete();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send_frame(0, 8'hA5, 1'b1);
        send_frame(0, 8'h3C, 1'b1);
        repeat (24) @(negedge clk);
        n_vec++;
        if (ev_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL b2b_count got %0d strobes want %0d", ev_q[0].size(), exp_q[0].size());
        end
        for (int k = 0; k < exp_q[0].size() && k < ev_q[0].size(); k++) begin
            n_vec++;
            if (ev_q[0][k] !== exp_q[0][k]) begin
                n_fail++;
                $display("FAIL b2b_ev%0d got cyc=%0d done=%b err=%b byte=%h busy=%b want cyc=%0d done=%b err=%b byte=%h busy=%b",
                         k, ev_q[0][k].cyc, ev_q[0][k].done, ev_q[0][k].err, ev_q[0][k].data, ev_q[0][k].busy,
                         exp_q[0][k].cyc, exp_q[0][k].done, exp_q[0][k].err, exp_q[0][k].data, exp_q[0][k].busy);
            end
        end
        n_vec++;
        if (u_if16.rxbyte !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_hold got %h want 3c", u_if16.rxbyte);
        end
        ev_q[0].delete();
        exp_q[0].delete();
    endtask

    task automatic test_glitch();
        logic exp_busy;
        @(negedge clk);
        rx_v[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 4) rx_v[0] = 1'b1;
            // Busy from E0 (= E3) until the mid-start sample at E0+8.
            exp_busy = (k >= 3 && k <= 10);
            n_vec++;
            if (u_if16.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL glitch_busy k=%0d got %b want %b", k, u_if16.busy, exp_busy);
            end
        end
        repeat (200) @(negedge clk);
        n_vec++;
        if (ev_q[0].size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_strobe got %0d strobes want 0", ev_q[0].size());
        end
        n_vec++;
        if (u_if16.rxbyte !== last_byte[0]) begin
            n_fail++;
            $display("FAIL glitch_hold got %h want %h", u_if16.rxbyte, last_byte[0]);
        end
        ev_q[0].delete();
    endtask

    task automatic test_framing();
        @(negedge clk);
        send_frame(0, 8'h55, 1'b0);
        repeat (40 * 16) @(negedge clk);
        n_vec++;
        if (u_if16.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL break_busy got %b want 1", u_if16.busy);
        end
        rx_v[0] = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++;
        if (u_if16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_release got %b want 0", u_if16.busy);
        end
        repeat (200) @(negedge clk);
        n_vec++;
        if (ev_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL framing_count got %0d strobes want %0d", ev_q[0].size(), exp_q[0].size());
        end
        for (int k = 0; k < exp_q[0].size() && k < ev_q[0].size(); k++) begin
            n_vec++;
            if (ev_q[0][k] !== exp_q[0][k]) begin
                n_fail++;
                $display("FAIL framing_ev%0d got cyc=%0d done=%b err=%b byte=%h busy=%b want cyc=%0d done=%b err=%b byte=%h busy=%b",
                         k, ev_q[0][k].cyc, ev_q[0][k].done, ev_q[0][k].err, ev_q[0][k].data, ev_q[0][k].busy,
                         exp_q[0][k].cyc, exp_q[0][k].done, exp_q[0][k].err, exp_q[0][k].data, exp_q[0][k].busy);
            end
        end
        n_vec++;
        if (u_if16.rxbyte !== last_byte[0]) begin
            n_fail++;
            $display("FAIL framing_hold got %h want %h", u_if16.rxbyte, last_byte[0]);
        end
        ev_q[0].delete();
        exp_q[0].delete();
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        rx_v[0] = 1'b0;
        repeat (16) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (4 * 16 + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({u_if16.rxbyte, u_if16.rxdone, u_if16.rxerr, u_if16.busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h/%b/%b/%b want 00/0/0/0", u_if16.rxbyte, u_if16.rxdone, u_if16.rxerr, u_if16.busy);
        end
        for (int i = 0; i < 3; i++) last_byte[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_vec++;
        if (ev_q[0].size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_strobe got %0d strobes want 0", ev_q[0].size());
        end
        ev_q[0].delete();
        send_frame(0, 8'h81, 1'b1);
        repeat (24) @(negedge clk);
        n_vec++;
        if (ev_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL after_reset_count got %0d strobes want %0d", ev_q[0].size(), exp_q[0].size());
        end
        for (int k = 0; k < exp_q[0].size() && k < ev_q[0].size(); k++) begin
            n_vec++;
            if (ev_q[0][k] !== exp_q[0][k]) begin
                n_fail++;
                $display("FAIL after_reset_ev%0d got cyc=%0d done=%b err=%b byte=%h busy=%b want cyc=%0d done=%b err=%b byte=%h busy=%b",
                         k, ev_q[0][k].cyc, ev_q[0][k].done, ev_q[0][k].err, ev_q[0][k].data, ev_q[0][k].busy,
                         exp_q[0][k].cyc, exp_q[0][k].done, exp_q[0][k].err, exp_q[0][k].data, exp_q[0][k].busy);
            end
        end
        ev_q[0].delete();
        exp_q[0].delete();
    endtask

    task automatic test_param_sweep();
        for (int sel = 1; sel <= 2; sel++) begin
            @(negedge clk);
            send_frame(sel, 8'h00, 1'b1);
            send_frame(sel, 8'hFF, 1'b1);
            repeat (5) @(negedge clk);
            send_frame(sel, 8'($urandom), 1'b1);
            repeat (24) @(negedge clk);
            n_vec++;
            if (ev_q[sel].size() !== exp_q[sel].size()) begin
                n_fail++;
                $display("FAIL sweep%0d_count got %0d strobes want %0d", cpb_of(sel), ev_q[sel].size(), exp_q[sel].size());
            end
            for (int k = 0; k < exp_q[sel].size() && k < ev_q[sel].size(); k++) begin
                n_vec++;
                if (ev_q[sel][k] !== exp_q[sel][k]) begin
                    n_fail++;
                    $display("FAIL sweep%0d_ev%0d got cyc=%0d done=%b err=%b byte=%h busy=%b want cyc=%0d done=%b err=%b byte=%h busy=%b",
                             cpb_of(sel), k, ev_q[sel][k].cyc, ev_q[sel][k].done, ev_q[sel][k].err, ev_q[sel][k].data, ev_q[sel][k].busy,
                             exp_q[sel][k].cyc, exp_q[sel][k].done, exp_q[sel][k].err, exp_q[sel][k].data, exp_q[sel][k].busy);
                end
            end
            ev_q[sel].delete();
            exp_q[sel].delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_v[i]      = 1'b1;
            last_byte[i] = 8'h00;
        end
        test_reset();
        test_single_and_random();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's transmit-only 8N1 UART.
- Oversamples the rx line at CLKS_PER_BIT system clocks per bit and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB-first and checks the stop bit.
- Presents each received byte with a one-cycle done strobe, or flags a framing error. Sits between the FPGA rx pin and user logic.

Parameters:
- CLKS_PER_BIT, 16, system clocks per UART bit. Must be even and at least 4. HALF = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line from pin, asynchronous; idles high
- rxbyte  output  8  last correctly received byte; holds its value between frames
- rxdone  output  1  one-cycle pulse; rxbyte is valid from that cycle on
- rxerr  output  1  one-cycle pulse on framing error (stop bit sampled low)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bit counter, sample counter and shift register = 0.
  - Both synchroniser flops = 1.
  - rxbyte=8'h00, rxdone=0, rxerr=0, busy=0.
- Synchroniser: rx passes through 2 flops to give rx_s. Only rx_s is used internally.
- Edge numbering: rising edges after the rx pin falls are E1, E2, … rx_s is low after E2. The FSM first sees it at E3, called E0 below.
- States:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: cnt increments each edge. At cnt==HALF-1 (edge E0+HALF), sample rx_s:
    - rx_s==0: go to DATA with cnt=0, bitidx=0.
    - rx_s==1: go to IDLE (glitch reject); no strobe.
  - DATA: cnt counts 0..CLKS_PER_BIT-1. At the terminal count:
    - shift = {rx_s, shift[7:1]}; bitidx++; cnt=0.
    - After the 8th sample (bitidx 7, edge E0+HALF+8*CLKS_PER_BIT), go to STOP.
  - STOP: at the terminal count (edge E0+HALF+9*CLKS_PER_BIT), sample rx_s:
    - rx_s==1: rxbyte<=shift, rxdone<=1 for exactly one cycle, go to IDLE.
    - rx_s==0: rxerr<=1 for exactly one cycle, rxbyte unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A line held low never retriggers a frame.
- Latency: rxdone/rxerr are high in the cycle after edge E(3+HALF+9*CLKS_PER_BIT). For the default: after E155.
- rxdone and rxerr are mutually exclusive and never high in consecutive cycles for the same frame.
- Back-to-back frames: IDLE accepts a new start edge on the first edge after STOP completes. A following start bit is therefore caught even when the stop bit lasts exactly one bit time.
- Mid-frame reset: aborts immediately; no strobe is produced; the next frame starts clean.
- Counter width is $clog2(CLKS_PER_BIT); bitidx is 3 bits. No arithmetic overflow is possible within a frame.
- No FIFO, no overrun detection: the consumer must capture rxbyte before the next rxdone.

Decomposition:
- Shared include uart_defs.vh, used by both tx and rx:
  - state encodings (IDLE, START, DATA, STOP, BREAK as localparams)
  - UART_DATA_BITS=8
  - the default CLKS_PER_BIT
- One natural sub-module: uart_sync2. A 2-flop synchroniser with async active-low reset to 1, instanced on rx.

Test Plan:
- Single byte, default params: send 8'h25 (start, bits 1,0,1,0,0,1,0,0, stop) at 16 clk/bit -> rxdone pulses once at the cycle after E155; rxbyte=8'h25; rxerr=0; busy falls with rxdone.
- Back-to-back: send 8'hA5 then 8'h3C with no idle gap between the stop bit and the next start bit -> two rxdone pulses exactly 160 cycles apart; rxbyte reads 8'hA5, then 8'h3C.
- Glitch reject: rx low for 4 clocks, then high -> busy rises, falls at E0+8; rxdone=rxerr=0; rxbyte unchanged.
- Framing error: send 8'h55 with the stop bit low, then hold rx low for 40 bit times -> one rxerr pulse; rxbyte keeps its previous value; state stays BREAK and busy=1 until rx returns high, then IDLE with no extra frame.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 8'hFF, release, then send 8'h81 -> no strobe for the aborted frame; outputs read 0 during reset; 8'h81 is received correctly.
- Parameter sweep: CLKS_PER_BIT=4 and 10 with 8'h00 and 8'hFF -> correct bytes; rxdone lands at E(3+HALF+9*CLKS_PER_BIT).
